// File: rtl/truth_table_capture.sv
// Truth-table capture for a 4-input combinational DUT.
// Tracks coverage, conflicting repeats and ordering, then grades the table.
module truth_table_capture #(
  parameter logic [15:0] EXPECTED     = 16'h0000,
  parameter bit          STRICT_ORDER = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [3:0]  in_vec,
  input  logic        f_in,
  output logic [15:0] table_out,
  output logic [15:0] seen,
  output logic [4:0]  count,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        conflict,
  output logic        order_err
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        take;
  logic        first;
  logic        last;
  logic [15:0] tbl_nx;
  logic        conf_nx;
  logic        ord_nx;

  always_comb begin
    take           = (state == CAPTURE) && in_valid && !start;
    first          = !seen[in_vec];
    tbl_nx         = table_out;
    tbl_nx[in_vec] = f_in;
    conf_nx        = conflict |
                     (!first && (table_out[in_vec] != f_in));
    ord_nx         = order_err |
                     (STRICT_ORDER && ({1'b0, in_vec} != count));
    last           = take && first && (count == 5'd15);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CAPTURE;
      CAPTURE: begin
        if (start)     state_nx = CAPTURE;
        else if (last) state_nx = DONE;
      end
      DONE:    if (start) state_nx = CAPTURE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CAPTURE);
    done = (state == DONE);
  end

  // Verdict uses next-state values so it is ready as done rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      table_out <= '0;
      seen      <= '0;
      count     <= '0;
      conflict  <= 1'b0;
      order_err <= 1'b0;
      pass      <= 1'b0;
    end else if (start) begin
      table_out <= '0;
      seen      <= '0;
      count     <= '0;
      conflict  <= 1'b0;
      order_err <= 1'b0;
      pass      <= 1'b0;
    end else if (take) begin
      table_out      <= tbl_nx;
      seen[in_vec]   <= 1'b1;
      conflict       <= conf_nx;
      order_err      <= ord_nx;
      if (first) count <= count + 5'd1;
      if (last) begin
        pass <= (tbl_nx == EXPECTED) && !conf_nx && !ord_nx;
      end
    end
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture.
// Two instances share stimulus: relaxed and strict ordering.
module tb_truth_table_capture;

  localparam logic [15:0] EXP = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_vec = '0;
  logic        f_in = 1'b0;

  logic [15:0] tbl0, seen0, tbl1, seen1;
  logic [4:0]  cnt0, cnt1;
  logic        busy0, done0, pass0, conf0, ord0;
  logic        busy1, done1, pass1, conf1, ord1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  truth_table_capture #(.EXPECTED(EXP), .STRICT_ORDER(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_vec(in_vec), .f_in(f_in), .table_out(tbl0), .seen(seen0),
    .count(cnt0), .busy(busy0), .done(done0), .pass(pass0),
    .conflict(conf0), .order_err(ord0)
  );

  truth_table_capture #(.EXPECTED(EXP), .STRICT_ORDER(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_vec(in_vec), .f_in(f_in), .table_out(tbl1), .seen(seen1),
    .count(cnt1), .busy(busy1), .done(done1), .pass(pass1),
    .conflict(conf1), .order_err(ord1)
  );

  typedef struct {
    logic [3:0]  vec;
    logic        f;
    logic [4:0]  cnt;
    logic [15:0] seen;
    logic        done;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] v, input logic f);
    in_valid = 1'b1;
    in_vec   = v;
    f_in     = f;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send_all(input logic [3:0] skip, input bit use_skip);
    for (int i = 0; i < 16; i++) begin
      if (!(use_skip && i == int'(skip))) send(4'(i), EXP[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vt[i].vec  = 4'(i);
      vt[i].f    = EXP[i];
      vt[i].cnt  = 5'(i + 1);
      vt[i].seen = 16'((17'd1 << (i + 1)) - 17'd1);
      vt[i].done = (i == 15);
    end

    rst = 1'b1;
    #12;
    check("reset_busy", {31'd0, busy0}, 0);
    check("reset_cnt", {27'd0, cnt0}, 0);
    check("reset_tbl", {16'd0, tbl0}, 0);
    rst = 1'b0;
    cyc();

    send(4'd5, 1'b1);
    check("idle_ignores", {27'd0, cnt0}, 0);

    // Exhaustive match, table-driven
    pulse_start();
    check("start_busy", {31'd0, busy0}, 1);
    for (int i = 0; i < 16; i++) begin
      send(vt[i].vec, vt[i].f);
      check($sformatf("ex_cnt%0d", i), {27'd0, cnt0}, {27'd0, vt[i].cnt});
      check($sformatf("ex_seen%0d", i), {16'd0, seen0}, {16'd0, vt[i].seen});
      check($sformatf("ex_done%0d", i), {31'd0, done0}, {31'd0, vt[i].done});
    end
    check("ex_tbl", {16'd0, tbl0}, {16'd0, EXP});
    check("ex_pass", {31'd0, pass0}, 1);
    check("ex_conf", {31'd0, conf0}, 0);
    check("ex_pass_strict", {31'd0, pass1}, 1);
    check("ex_ord_strict", {31'd0, ord1}, 0);
    send(4'd2, 1'b0);
    check("done_holds_tbl", {16'd0, tbl0}, {16'd0, EXP});

    // Mismatch on vector 6
    pulse_start();
    for (int i = 0; i < 16; i++) send(4'(i), EXP[i] ^ (i == 6));
    check("mm_done", {31'd0, done0}, 1);
    check("mm_tbl", {16'd0, tbl0}, 32'h0000A583);
    check("mm_pass", {31'd0, pass0}, 0);
    check("mm_conf", {31'd0, conf0}, 0);

    // Repeat and conflict
    pulse_start();
    send(4'd3, 1'b1);
    check("rp_cnt1", {27'd0, cnt0}, 1);
    check("rp_conf0", {31'd0, conf0}, 0);
    send(4'd3, 1'b0);
    check("rp_cnt_same", {27'd0, cnt0}, 1);
    check("rp_conf1", {31'd0, conf0}, 1);
    send_all(4'd3, 1'b1);
    check("rp_done", {31'd0, done0}, 1);
    check("rp_bit3", {31'd0, tbl0[3]}, 0);
    check("rp_pass", {31'd0, pass0}, 0);

    // Out-of-order with a gap
    pulse_start();
    send(4'd1, EXP[1]);
    check("oo_ord_strict", {31'd0, ord1}, 1);
    check("oo_ord_relax", {31'd0, ord0}, 0);
    send(4'd0, EXP[0]);
    for (int i = 2; i <= 7; i++) send(4'(i), EXP[i]);
    check("oo_cnt8", {27'd0, cnt0}, 8);
    for (int i = 0; i < 3; i++) cyc();
    check("oo_gap_cnt", {27'd0, cnt0}, 8);
    check("oo_gap_busy", {31'd0, busy0}, 1);
    for (int i = 8; i < 16; i++) send(4'(i), EXP[i]);
    check("oo_done_relax", {31'd0, done0}, 1);
    check("oo_done_strict", {31'd0, done1}, 1);
    check("oo_pass_relax", {31'd0, pass0}, 1);
    check("oo_pass_strict", {31'd0, pass1}, 0);

    // Reset mid-capture
    pulse_start();
    for (int i = 0; i < 9; i++) send(4'(i), EXP[i]);
    check("mr_cnt9", {27'd0, cnt0}, 9);
    check("mr_tbl", {16'd0, tbl0}, 32'h000001C3);
    #2 rst = 1'b1;
    #1;
    check("mr_tbl0", {16'd0, tbl0}, 0);
    check("mr_seen0", {16'd0, seen0}, 0);
    check("mr_cnt0", {27'd0, cnt0}, 0);
    check("mr_busy0", {31'd0, busy0}, 0);
    #2 rst = 1'b0;
    cyc();
    send(4'd9, 1'b1);
    send(4'd10, 1'b0);
    check("mr_ignored", {27'd0, cnt0}, 0);
    check("mr_idle", {31'd0, busy0}, 0);

    // Restart from DONE with a concurrent sample
    pulse_start();
    send_all(4'd0, 1'b0);
    check("rs_done", {31'd0, done0}, 1);
    start    = 1'b1;
    in_valid = 1'b1;
    in_vec   = 4'd0;
    f_in     = 1'b1;
    cyc();
    start    = 1'b0;
    in_valid = 1'b0;
    check("rs_busy", {31'd0, busy0}, 1);
    check("rs_done0", {31'd0, done0}, 0);
    check("rs_seen", {16'd0, seen0}, 0);
    check("rs_cnt", {27'd0, cnt0}, 0);
    check("rs_pass", {31'd0, pass0}, 0);
    cyc();
    check("rs_dropped", {27'd0, cnt0}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
